// File: rtl/systolic_skew_feeder.sv
// Captures a SIZExSIZE matrix on start and streams it into the array lanes with diagonal skew (lane k delayed k steps).
// Outputs decode combinationally from registered state: step 0 appears the cycle after start; stall holds the step and all outputs.
module systolic_skew_feeder #(
   parameter int WIDTH = 16,
   parameter int SIZE  = 10
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  start_i,
   input  logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]  a_i,
   input  logic                                  stall_i,
   output logic                                  busy_o,
   output logic [SIZE-1:0][WIDTH-1:0]            lane_data_o,
   output logic [SIZE-1:0]                       lane_valid_o,
   output logic                                  last_o,
   output logic                                  done_o
);

   localparam int STEP_W = $clog2(2*SIZE);
   localparam int IDX_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2*SIZE-2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DONE
   } state_e;

   state_e                               state_q, state_d;
   logic [STEP_W-1:0]                    step_q, step_d;
   logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0] mat_q;
   logic                                 load;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
      end
   end

   // Matrix is only written on an accepted start, so later changes on a_i never reach the lanes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mat_q <= '0;
      end else if (load) begin
         mat_q <= a_i;
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_STREAM;
               step_d  = '0;
               load    = 1'b1;
            end
         end
         S_STREAM: begin
            if (!stall_i) begin
               if (step_q == LAST_STEP) begin
                  state_d = S_DONE;
                  step_d  = '0;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            step_d  = '0;
         end
      endcase
   end

   // Lane k carries row (step - k) of column k while that row index lies inside the matrix.
   always_comb begin
      logic [STEP_W-1:0] diff;
      diff         = '0;
      lane_valid_o = '0;
      lane_data_o  = '0;
      for (int k = 0; k < SIZE; k++) begin
         diff = step_q - STEP_W'(k);
         if ((state_q == S_STREAM) && (step_q >= STEP_W'(k)) && (diff < STEP_W'(SIZE))) begin
            lane_valid_o[k] = 1'b1;
            lane_data_o[k]  = mat_q[IDX_W'(diff)][k];
         end
      end
   end

   assign busy_o = (state_q == S_STREAM) || (state_q == S_DONE);
   assign last_o = (state_q == S_STREAM) && (step_q == LAST_STEP);
   assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: stimulus queues expected beats, a negedge monitor pops and compares.
module tb_systolic_skew_feeder;

   typedef logic [9:0][9:0][15:0] mat_t;
   typedef struct packed {
      logic             done;
      logic             last;
      logic [9:0]       vld;
      logic [9:0][15:0] dat;
   } beat_t;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             start_i;
   mat_t             a_i;
   logic             stall_i;
   logic             busy_o;
   logic [9:0][15:0] lane_data_o;
   logic [9:0]       lane_valid_o;
   logic             last_o;
   logic             done_o;

   int    tests = 0;
   int    fails = 0;
   beat_t exp_q[$];
   beat_t mon_got, mon_exp;
   mat_t  m1, m2;

   systolic_skew_feeder #(.WIDTH(16), .SIZE(10)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .a_i          (a_i),
      .stall_i      (stall_i),
      .busy_o       (busy_o),
      .lane_data_o  (lane_data_o),
      .lane_valid_o (lane_valid_o),
      .last_o       (last_o),
      .done_o       (done_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic mat_t make_m1();
      mat_t m;
      for (int r = 0; r < 10; r++)
         for (int c = 0; c < 10; c++)
            m[r][c] = 16'(r*20 + c + 1);
      m[0][0] = 16'd123; m[0][1] = 16'd45; m[0][2] = 16'd89;
      m[1][0] = 16'd76;  m[1][1] = 16'd233; m[9][9] = 16'd12;
      return m;
   endfunction

   function automatic mat_t make_m2();
      mat_t m;
      for (int r = 0; r < 10; r++)
         for (int c = 0; c < 10; c++)
            m[r][c] = 16'(-(r*10 + c + 1) * 7);
      m[0][0] = 16'hFE86;
      return m;
   endfunction

   function automatic beat_t mk_beat(input mat_t m, input int t);
      beat_t b;
      b = '0;
      for (int k = 0; k < 10; k++) begin
         if (t - k >= 0 && t - k < 10) begin
            b.vld[k] = 1'b1;
            b.dat[k] = m[t-k][k];
         end
      end
      b.last = (t == 18);
      return b;
   endfunction

   task automatic push_run(input mat_t m, input int stall_step, input int stall_extra,
                           input int nsteps, input bit with_done);
      beat_t d;
      for (int t = 0; t < nsteps; t++) begin
         exp_q.push_back(mk_beat(m, t));
         if (t == stall_step)
            for (int i = 0; i < stall_extra; i++) exp_q.push_back(mk_beat(m, t));
      end
      if (with_done) begin
         d = '0;
         d.done = 1'b1;
         exp_q.push_back(d);
      end
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string nm);
      check({nm, "_busy"}, 32'(busy_o), 32'd0);
      check({nm, "_done"}, 32'(done_o), 32'd0);
      check({nm, "_last"}, 32'(last_o), 32'd0);
      check({nm, "_vld"},  32'(lane_valid_o), 32'd0);
      check({nm, "_dat_nz"}, 32'(lane_data_o != '0), 32'd0);
   endtask

   // Scoreboard monitor: any cycle with a visible output consumes one expected beat.
   always @(negedge clk_i) begin
      if (!rst_i && (lane_valid_o != '0 || last_o || done_o)) begin
         mon_got = {done_o, last_o, lane_valid_o, lane_data_o};
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got vld=%b last=%b done=%b, required no output",
                     lane_valid_o, last_o, done_o);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
               fails++;
               $display("FAIL beat: got vld=%b last=%b done=%b dat=%h, required vld=%b last=%b done=%b dat=%h",
                        mon_got.vld, mon_got.last, mon_got.done, mon_got.dat,
                        mon_exp.vld, mon_exp.last, mon_exp.done, mon_exp.dat);
            end
         end
      end
   end

   task automatic point_checks(input int id, input int c);
      if (id == 1 && c == 1) begin
         check("r1_s0_vld", 32'(lane_valid_o), 32'h001);
         check("r1_s0_l0", 32'(lane_data_o[0]), 32'd123);
      end
      if (id == 1 && c == 2) begin
         check("r1_s1_vld", 32'(lane_valid_o), 32'h003);
         check("r1_s1_l0", 32'(lane_data_o[0]), 32'd76);
         check("r1_s1_l1", 32'(lane_data_o[1]), 32'd45);
      end
      if (id == 1 && c == 19) begin
         check("r1_s18_vld", 32'(lane_valid_o), 32'h200);
         check("r1_s18_l9", 32'(lane_data_o[9]), 32'd12);
         check("r1_s18_last", 32'(last_o), 32'd1);
      end
      if (id == 2 && c == 1) check("r2_neg_l0", 32'(lane_data_o[0]), 32'h0000FE86);
      if (id == 2 && c == 9) check("r2_stall_vld", 32'(lane_valid_o), 32'h03F);
      if (id == 2 && c == 10) check("r2_resume_vld", 32'(lane_valid_o), 32'h07F);
      if (id == 4 && c == 1) begin
         check("r4_restart_vld", 32'(lane_valid_o), 32'h001);
         check("r4_restart_l0", 32'(lane_data_o[0]), 32'h0000FE86);
      end
   endtask

   task automatic run(input int id, input mat_t m, input int stall_from, input int stall_len,
                      input int repulse_at, input int abort_at, input int exp_done);
      bit seen;
      seen = 1'b0;
      a_i = m;
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int c = 1; c <= 60 && !seen; c++) begin
         stall_i = (c >= stall_from && c < stall_from + stall_len);
         start_i = (c == repulse_at);
         if (c == repulse_at) a_i = '1;
         if (c == abort_at) begin
            rst_i = 1'b1;
            @(posedge clk_i); @(posedge clk_i); #1;
            rst_i = 1'b0;
            stall_i = 1'b0;
            @(negedge clk_i);
            check_idle_outputs("abort");
            check("abort_q_empty", 32'(exp_q.size()), 32'd0);
            return;
         end
         @(negedge clk_i);
         point_checks(id, c);
         if (done_o) begin
            seen = 1'b1;
            check("done_cycle", 32'(c), 32'(exp_done));
         end
         @(posedge clk_i); #1;
      end
      start_i = 1'b0;
      stall_i = 1'b0;
      if (!seen) begin
         check("done_timeout", 32'd0, 32'd1);
      end else begin
         @(negedge clk_i);
         check("busy_fall", 32'(busy_o), 32'd0);
         check("q_empty", 32'(exp_q.size()), 32'd0);
      end
      @(posedge clk_i); #1;
   endtask

   initial begin
      m1 = make_m1();
      m2 = make_m2();
      rst_i = 1'b1;
      start_i = 1'b0;
      stall_i = 1'b0;
      a_i = '0;
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check_idle_outputs("reset");
      @(posedge clk_i); #1;

      push_run(m1, -1, 0, 19, 1'b1);
      run(1, m1, 0, 0, 5, 0, 20);

      push_run(m2, 5, 3, 19, 1'b1);
      run(2, m2, 6, 3, 0, 0, 23);

      push_run(m1, -1, 0, 7, 1'b0);
      run(3, m1, 0, 0, 0, 8, 0);

      push_run(m2, -1, 0, 19, 1'b1);
      run(4, m2, 0, 0, 0, 0, 20);

      repeat (3) @(posedge clk_i);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

endmodule
